memory_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port 8x4 synchronous-read data memory. Two requesters (e.g. two processor/cache controllers) issue independent read or write requests; the block serialises them onto the memory's one port, sequences each access, and returns read data and a one-cycle acknowledge to the winning requester. It sits between the requesters and the memory, and is the only driver of the memory's `write`, `address` and `data_in` inputs.

---
 rtl/memory_arbiter.sv | 111 +++++++++++
 tb/tb_memory_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter that serialises two requesters onto one synchronous-read
// memory port. Each access takes IDLE -> ACCESS -> CAPTURE, and the ack follows in IDLE.
`timescale 1ns/1ps

module memory_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  write0,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  busy,
    output logic                  owner,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE
    } state_t;

    state_t state;

    logic                  elig0;
    logic                  elig1;
    logic                  grant_valid;
    logic                  winner;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    // A port still showing its ack is finishing the previous transaction, so it
    // cannot win; ties go to the port that did not hold the last grant.
    always_comb begin
        elig0       = req0 && !ack0;
        elig1       = req1 && !ack1;
        grant_valid = elig0 || elig1;
        winner      = elig1 && (!elig0 || !owner);
        sel_write   = winner ? write1   : write0;
        sel_address = winner ? address1 : address0;
        sel_data    = winner ? data_in1 : data_in0;
    end

    // mem_address and mem_data_in double as the latched request fields; they
    // hold the last granted values until the next grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            data_out0   <= '0;
            data_out1   <= '0;
            busy        <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner       <= winner;
                        mem_write   <= sel_write;
                        mem_address <= sel_address;
                        mem_data_in <= sel_data;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    if (owner) begin
                        data_out1 <= mem_data_out;
                        ack1      <= 1'b1;
                    end else begin
                        data_out0 <= mem_data_out;
                        ack0      <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 8x4 memory, a per-port
// transaction driver and an expected-data scoreboard.
`timescale 1ns/1ps

module tb_memory_arbiter;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1, write0, write1;
    logic [AW-1:0] address0, address1;
    logic [DW-1:0] data_in0, data_in1;
    logic          ack0, ack1, busy, owner, mem_write;
    logic [DW-1:0] data_out0, data_out1, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .address0(address0), .address1(address1),
        .data_in0(data_in0), .data_in1(data_in1),
        .ack0(ack0), .ack1(ack1), .data_out0(data_out0), .data_out1(data_out1),
        .busy(busy), .owner(owner), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory; a write returns the new word.
    logic [DW-1:0] mem [8] = '{4'h3, 4'h1, 4'h6, 4'h8, 4'hE, 4'h2, 4'hD, 4'h5};
    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem_write ? mem_data_in : mem[mem_address];
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic [DW-1:0] ref_mem [8] = '{4'h3, 4'h1, 4'h6, 4'h8, 4'hE, 4'h2, 4'hD, 4'h5};
    txn_t          pend0[$], pend1[$];
    logic [DW-1:0] exp0[$], exp1[$];
    logic [DW-1:0] hold0, hold1;
    int            ack_port[$], ack_cyc[$];
    int            checks = 0, errors = 0, cyc = 0;
    int            wr_cycles, busy_gaps;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    bit            track_busy, adv0, adv1;
    int            c0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the head of a port's queue and record what its ack must return.
    task automatic drive(input int p);
        txn_t          t;
        logic [DW-1:0] e;
        if (p == 0) begin
            if (pend0.size() == 0) begin req0 = 1'b0; return; end
            t = pend0[0];
            req0 = 1'b1; write0 = t.wr; address0 = t.addr; data_in0 = t.data;
        end else begin
            if (pend1.size() == 0) begin req1 = 1'b0; return; end
            t = pend1[0];
            req1 = 1'b1; write1 = t.wr; address1 = t.addr; data_in1 = t.data;
        end
        e = t.wr ? t.data : ref_mem[t.addr];
        if (t.wr) ref_mem[t.addr] = t.data;
        if (p == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic issue(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        if (p == 0) begin
            pend0.push_back(t);
            if (pend0.size() == 1) drive(0);
        end else begin
            pend1.push_back(t);
            if (pend1.size() == 1) drive(1);
        end
    endtask

    // One clock: observe at the falling edge, then advance requesters whose ack was seen.
    task automatic step();
        @(negedge clock);
        if (!reset) begin
            if (ack0) begin
                checks++;
                assert (exp0.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack0: observed ack0=1 expected no outstanding ack");
                end
                if (exp0.size() > 0) hold0 = exp0.pop_front();
                ack_port.push_back(0); ack_cyc.push_back(cyc);
            end
            if (ack1) begin
                checks++;
                assert (exp1.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack1: observed ack1=1 expected no outstanding ack");
                end
                if (exp1.size() > 0) hold1 = exp1.pop_front();
                ack_port.push_back(1); ack_cyc.push_back(cyc);
            end
            check_vec("data_out0", data_out0, hold0);
            check_vec("data_out1", data_out1, hold1);
            if (mem_write) begin
                wr_cycles++; wr_addr = mem_address; wr_data = mem_data_in;
            end
            if (track_busy && !busy && !ack0 && !ack1) busy_gaps++;
        end
        adv0 = ack0 && !reset;
        adv1 = ack1 && !reset;
        @(posedge clock);
        #1;
        cyc++;
        if (adv0 && pend0.size() > 0) begin void'(pend0.pop_front()); drive(0); end
        if (adv1 && pend1.size() > 0) begin void'(pend1.pop_front()); drive(1); end
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        check_vec("drain_timeout", (n < maxc), 1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
        hold0 = '0; hold1 = '0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic check_reset_values();
        check_vec("rst_ack0", ack0, 0);
        check_vec("rst_ack1", ack1, 0);
        check_vec("rst_data_out0", data_out0, 0);
        check_vec("rst_data_out1", data_out1, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_owner", owner, 1);
        check_vec("rst_mem_write", mem_write, 0);
        check_vec("rst_mem_address", mem_address, 0);
        check_vec("rst_mem_data_in", mem_data_in, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        address0 = '0; address1 = '0; data_in0 = '0; data_in1 = '0;
        hold0 = '0; hold1 = '0; track_busy = 0; wr_cycles = 0; busy_gaps = 0;
        wr_addr = '0; wr_data = '0; adv0 = 0; adv1 = 0;

        do_reset(3);
        check_reset_values();

        // Single read of word 0 right after reset.
        c0 = cyc;
        ack_port.delete(); ack_cyc.delete();
        issue(0, 1'b0, 3'd0, 4'h0);
        run_until_idle(20);
        check_vec("t1_ack_count", ack_port.size(), 1);
        check_vec("t1_ack_port", (ack_port.size() > 0) ? ack_port[0] : 9, 0);
        check_vec("t1_latency", (ack_cyc.size() > 0) ? ack_cyc[0] - c0 : -1, 3);

        // Port 1 writes 1010 to address 5, then port 0 reads it back.
        wr_cycles = 0;
        issue(1, 1'b1, 3'd5, 4'hA);
        run_until_idle(20);
        check_vec("t2_write_cycles", wr_cycles, 1);
        check_vec("t2_write_addr", wr_addr, 5);
        check_vec("t2_write_data", wr_data, 4'hA);
        wr_cycles = 0;
        issue(0, 1'b0, 3'd5, 4'h0);
        run_until_idle(20);
        check_vec("t2_read_no_write", wr_cycles, 0);

        // Simultaneous requests straight after reset.
        do_reset(2);
        ack_port.delete(); ack_cyc.delete();
        issue(0, 1'b0, 3'd1, 4'h0);
        issue(1, 1'b0, 3'd4, 4'h0);
        run_until_idle(30);
        check_vec("t3_ack_count", ack_port.size(), 2);
        check_vec("t3_first", (ack_port.size() > 0) ? ack_port[0] : 9, 0);
        check_vec("t3_second", (ack_port.size() > 1) ? ack_port[1] : 9, 1);
        check_vec("t3_spacing", (ack_cyc.size() > 1) ? ack_cyc[1] - ack_cyc[0] : -1, 3);

        // Both ports streaming three transactions each.
        ack_port.delete(); ack_cyc.delete();
        issue(0, 1'b1, 3'd3, 4'hC);
        issue(0, 1'b0, 3'd3, 4'h0);
        issue(0, 1'b0, 3'd1, 4'h0);
        issue(1, 1'b0, 3'd6, 4'h0);
        issue(1, 1'b1, 3'd7, 4'h9);
        issue(1, 1'b0, 3'd7, 4'h0);
        busy_gaps = 0;
        step();
        track_busy = 1;
        run_until_idle(60);
        track_busy = 0;
        check_vec("t4_ack_count", ack_port.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_vec($sformatf("t4_order_%0d", i), (i < ack_port.size()) ? ack_port[i] : 9, i % 2);
            if (i > 0)
                check_vec($sformatf("t4_spacing_%0d", i), (i < ack_cyc.size()) ? ack_cyc[i] - ack_cyc[i-1] : -1, 3);
        end
        check_vec("t4_busy_gaps", busy_gaps, 0);

        // Reset during ACCESS of a port-0 write: write lands, no ack follows.
        ack_port.delete(); ack_cyc.delete();
        issue(0, 1'b1, 3'd2, 4'h7);
        step();
        check_vec("t5_in_access_write", mem_write, 1);
        check_vec("t5_in_access_busy", busy, 1);
        reset = 1'b1;
        req0 = 1'b0;
        pend0.delete(); exp0.delete();
        hold0 = '0; hold1 = '0;
        step();
        check_reset_values();
        reset = 1'b0;
        repeat (5) step();
        check_vec("t5_no_ack", ack_port.size(), 0);
        issue(1, 1'b0, 3'd2, 4'h0);
        run_until_idle(20);
        check_vec("t5_readback_acks", ack_port.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
